// File: rtl/four_input_or_checker_pkg.sv
// Shared types and constants for the four-input OR gate checker.
// State encodings, widths and the coverage one-hot helper.
package four_input_or_checker_pkg;

  localparam int VEC_W = 4;
  localparam int CNT_W = 8;
  localparam int COV_W = 16;

  localparam logic [COV_W-1:0] COV_ALL = 16'hFFFF;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [COV_W-1:0] vec_onehot(
    input logic [VEC_W-1:0] v
  );
    logic [COV_W-1:0] oh;
    oh = '0;
    oh[v] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/four_input_or_checker_or_gate_model.sv
// Golden model of the gate under test: x=a|b, y=c|d, z=a|b|c|d.
// Ports: vec (a=bit3 .. d=bit0) in; x, y, z out.
module or_gate_model
  import four_input_or_checker_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             x,
  output logic             y,
  output logic             z
);

  assign x = vec[3] | vec[2];
  assign y = vec[1] | vec[0];
  assign z = |vec;

endmodule

// File: rtl/four_input_or_checker.sv
// Runs samples of a 4-input OR gate against a model, counting errors/coverage.
// Ports: clk, rst, start, in_valid, in_vec, resp_x/y/z in; status and counters out.
module four_input_or_checker
  import four_input_or_checker_pkg::*;
#(
  parameter int MAX_SAMPLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [VEC_W-1:0] in_vec,
  input  logic             resp_x,
  input  logic             resp_y,
  input  logic             resp_z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [VEC_W-1:0] first_err_vec,
  output logic [COV_W-1:0] coverage,
  output logic [CNT_W-1:0] sample_count
);

  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(MAX_SAMPLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [COV_W-1:0] cov_q, cov_d;
  logic             fev_q, fev_d;
  logic [VEC_W-1:0] fvec_q, fvec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic exp_x, exp_y, exp_z;
  logic acc, mism;

  or_gate_model u_model (
    .vec (in_vec),
    .x   (exp_x),
    .y   (exp_y),
    .z   (exp_z)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    cov_d   = cov_q;
    fev_d   = fev_q;
    fvec_d  = fvec_q;

    // start wins over a same-cycle sample
    acc  = (state_q == ST_RUN) && in_valid
         && !start;
    mism = (resp_x != exp_x)
         | (resp_y != exp_y)
         | (resp_z != exp_z);

    unique case (1'b1)
      start: begin
        state_d = ST_RUN;
        err_d   = '0;
        cnt_d   = '0;
        cov_d   = '0;
        fev_d   = 1'b0;
        fvec_d  = '0;
      end
      acc: begin
        cnt_d = cnt_q + 1'b1;
        cov_d = cov_q | vec_onehot(in_vec);
        if (mism && err_q != CNT_MAX)
          err_d = err_q + 1'b1;
        if (mism && !fev_q) begin
          fev_d  = 1'b1;
          fvec_d = in_vec;
        end
        if (cov_d == COV_ALL || cnt_d == MAX_C)
          state_d = ST_DONE;
      end
      default: begin
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0)
           && (cov_d == COV_ALL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      err_q   <= '0;
      cnt_q   <= '0;
      cov_q   <= '0;
      fev_q   <= 1'b0;
      fvec_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      cov_q   <= cov_d;
      fev_q   <= fev_d;
      fvec_q  <= fvec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;
  assign coverage        = cov_q;
  assign sample_count    = cnt_q;

endmodule

// File: tb/tb_four_input_or_checker.sv
// Directed bench for four_input_or_checker.
// Three instances cover MAX_SAMPLES = 64, 20 and 255.
module tb_four_input_or_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic start_c = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0] in_vec = '0;
  logic rx = 1'b0;
  logic ry = 1'b0;
  logic rz = 1'b0;

  logic busy_a, done_a, pass_a, fev_a;
  logic [7:0] err_a, cnt_a;
  logic [3:0] fvec_a;
  logic [15:0] cov_a;

  logic busy_b, done_b, pass_b, fev_b;
  logic [7:0] err_b, cnt_b;
  logic [3:0] fvec_b;
  logic [15:0] cov_b;

  logic busy_c, done_c, pass_c, fev_c;
  logic [7:0] err_c, cnt_c;
  logic [3:0] fvec_c;
  logic [15:0] cov_c;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  four_input_or_checker u_a (
    .clk(clk), .rst(rst), .start(start_a),
    .in_valid(in_valid), .in_vec(in_vec),
    .resp_x(rx), .resp_y(ry), .resp_z(rz),
    .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a),
    .first_err_valid(fev_a),
    .first_err_vec(fvec_a),
    .coverage(cov_a), .sample_count(cnt_a)
  );

  four_input_or_checker #(.MAX_SAMPLES(20)) u_b (
    .clk(clk), .rst(rst), .start(start_b),
    .in_valid(in_valid), .in_vec(in_vec),
    .resp_x(rx), .resp_y(ry), .resp_z(rz),
    .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b),
    .first_err_valid(fev_b),
    .first_err_vec(fvec_b),
    .coverage(cov_b), .sample_count(cnt_b)
  );

  four_input_or_checker #(.MAX_SAMPLES(255)) u_c (
    .clk(clk), .rst(rst), .start(start_c),
    .in_valid(in_valid), .in_vec(in_vec),
    .resp_x(rx), .resp_y(ry), .resp_z(rz),
    .busy(busy_c), .done(done_c),
    .pass(pass_c), .err_count(err_c),
    .first_err_valid(fev_c),
    .first_err_vec(fvec_c),
    .coverage(cov_c), .sample_count(cnt_c)
  );

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    tick();
  endtask

  // one sample; flip bits select wrong responses
  task automatic send(
    input logic [3:0] v,
    input logic fx,
    input logic fy
  );
    in_valid = 1'b1;
    in_vec = v;
    rx = (v[3] | v[2]) ^ fx;
    ry = (v[1] | v[0]) ^ fy;
    rz = |v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2;
    tick();
    rst = 1'b0;

    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_cov", 32'(cov_a), 32'd0);

    // S1: full sweep, all correct
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("s1_busy", 32'(busy_a), 32'd1);
    for (int i = 0; i < 15; i++)
      send(4'(i), 1'b0, 1'b0);
    check("s1_done15", 32'(done_a), 32'd0);
    check("s1_cov15", 32'(cov_a), 32'h7FFF);
    send(4'd15, 1'b0, 1'b0);
    check("s1_done", 32'(done_a), 32'd1);
    check("s1_busy0", 32'(busy_a), 32'd0);
    check("s1_pass", 32'(pass_a), 32'd1);
    check("s1_err", 32'(err_a), 32'd0);
    check("s1_cnt", 32'(cnt_a), 32'd16);
    send(4'd3, 1'b1, 1'b0);
    check("s1_hold", 32'(cnt_a), 32'd16);
    check("s1_hold_d", 32'(done_a), 32'd1);

    // S2: vec 4 answered with x = 0
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("s2_clr", 32'(cnt_a), 32'd0);
    for (int i = 0; i < 16; i++)
      send(4'(i), i == 4, 1'b0);
    check("s2_err", 32'(err_a), 32'd1);
    check("s2_fev", 32'(fev_a), 32'd1);
    check("s2_fvec", 32'(fvec_a), 32'h4);
    check("s2_pass", 32'(pass_a), 32'd0);
    check("s2_done", 32'(done_a), 32'd1);

    // S2b: only the first mismatch is kept
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("s2b_fev0", 32'(fev_a), 32'd0);
    send(4'd5, 1'b0, 1'b0);
    send(4'd6, 1'b0, 1'b1);
    send(4'd9, 1'b1, 1'b0);
    check("s2b_fvec", 32'(fvec_a), 32'h6);
    check("s2b_err", 32'(err_a), 32'd2);
    check("s2b_cov", 32'(cov_a), 32'h0260);

    // S4: rst mid-run
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 5; i++)
      send(4'(i + 8), 1'b1, 1'b0);
    check("s4_cnt5", 32'(cnt_a), 32'd5);
    pulse_rst();
    check("s4_busy", 32'(busy_a), 32'd0);
    check("s4_cnt", 32'(cnt_a), 32'd0);
    check("s4_err", 32'(err_a), 32'd0);
    check("s4_cov", 32'(cov_a), 32'd0);
    check("s4_fvec", 32'(fvec_a), 32'd0);
    check("s4_fev", 32'(fev_a), 32'd0);
    send(4'd1, 1'b1, 1'b0);
    send(4'd2, 1'b0, 1'b0);
    check("s4_ign", 32'(cnt_a), 32'd0);
    check("s4_ign_e", 32'(err_a), 32'd0);

    // rst beats start
    rst = 1'b1;
    start_a = 1'b1;
    tick();
    rst = 1'b0;
    start_a = 1'b0;
    check("rst_pri", 32'(busy_a), 32'd0);

    // S5: start in RUN with in_valid
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    send(4'd1, 1'b0, 1'b0);
    send(4'd2, 1'b0, 1'b1);
    send(4'd3, 1'b0, 1'b0);
    check("s5_cnt3", 32'(cnt_a), 32'd3);
    start_a = 1'b1;
    send(4'd5, 1'b1, 1'b0);
    start_a = 1'b0;
    check("s5_cnt", 32'(cnt_a), 32'd0);
    check("s5_err", 32'(err_a), 32'd0);
    check("s5_cov", 32'(cov_a), 32'd0);
    check("s5_fev", 32'(fev_a), 32'd0);
    check("s5_busy", 32'(busy_a), 32'd1);

    pulse_rst();

    // S3: MAX_SAMPLES = 20, vec 0..7 only
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 19; i++)
      send(4'(i % 8), 1'b0, 1'b0);
    check("s3_done19", 32'(done_b), 32'd0);
    send(4'd3, 1'b0, 1'b0);
    check("s3_done", 32'(done_b), 32'd1);
    check("s3_cnt", 32'(cnt_b), 32'd20);
    check("s3_cov", 32'(cov_b), 32'h00FF);
    check("s3_pass", 32'(pass_b), 32'd0);
    check("s3_err", 32'(err_b), 32'd0);

    pulse_rst();

    // S6: MAX_SAMPLES = 255, every answer wrong
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int i = 0; i < 254; i++)
      send(4'd0, 1'b1, 1'b0);
    check("s6_err254", 32'(err_c), 32'd254);
    check("s6_done254", 32'(done_c), 32'd0);
    send(4'd0, 1'b1, 1'b0);
    check("s6_err", 32'(err_c), 32'd255);
    check("s6_done", 32'(done_c), 32'd1);
    check("s6_cnt", 32'(cnt_c), 32'd255);
    check("s6_fvec", 32'(fvec_c), 32'd0);
    check("s6_pass", 32'(pass_c), 32'd0);
    send(4'd0, 1'b1, 1'b0);
    check("s6_nowrap", 32'(err_c), 32'd255);

    idle();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
